// File: rtl/dffe_pipe.sv
// dffe_pipe: WIDTH-bit, DEPTH-stage enable-gated delay line with fill tracking.
// The line advances only on en, holds otherwise, and flush synchronously
// clears every stage back to RESET_VAL. dout_vld marks dout as a real sample.
// Optional build macro DFFE_PIPE_STALL_CNT_EN adds a 16-bit stall_cnt output
// counting edges spent FULL with neither en nor flush.
module dffe_pipe #(
    parameter int                    WIDTH     = 8,
    parameter int                    DEPTH     = 4,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [WIDTH-1:0]               din,
    input  logic                           en,
    input  logic                           flush,
    output logic [WIDTH-1:0]               dout,
    output logic                           dout_vld,
    output logic [$clog2(DEPTH+1)-1:0]     fill_cnt
`ifdef DFFE_PIPE_STALL_CNT_EN
    ,
    output logic [15:0]                    stall_cnt
`endif
);

    localparam int               CNT_W   = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    localparam logic [1:0] EMPTY   = 2'b00;
    localparam logic [1:0] FILLING = 2'b01;
    localparam logic [1:0] FULL    = 2'b10;

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       state_q, state_d;
    logic             vld_q, vld_d;

    // Next-state: flush beats en; en shifts and counts up to DEPTH; otherwise hold.
    always_comb begin
        stage_d = stage_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        vld_d   = vld_q;
        if (flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_d[k] = RESET_VAL;
            end
            cnt_d   = '0;
            state_d = EMPTY;
            vld_d   = 1'b0;
        end else begin
            case (state_q)
                EMPTY, FILLING, FULL: begin
                    if (en) begin
                        stage_d[0] = din;
                        for (int k = 1; k < DEPTH; k++) begin
                            stage_d[k] = stage_q[k-1];
                        end
                        cnt_d   = (cnt_q == DEPTH_C) ? cnt_q : cnt_q + CNT_W'(1);
                        // Valid flag is derived from the new count so it can
                        // never disagree with fill_cnt.
                        vld_d   = (cnt_d == DEPTH_C);
                        state_d = vld_d ? FULL : FILLING;
                    end
                end
                default: begin
                    // Unused encoding: recover to a consistent empty state.
                    cnt_d   = '0;
                    state_d = EMPTY;
                    vld_d   = 1'b0;
                end
            endcase
        end
    end

    // Stage, count, state and valid registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= RESET_VAL;
            end
            cnt_q   <= '0;
            state_q <= EMPTY;
            vld_q   <= 1'b0;
        end else begin
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            vld_q   <= vld_d;
        end
    end

    assign dout     = stage_q[DEPTH-1];
    assign dout_vld = vld_q;
    assign fill_cnt = cnt_q;

`ifdef DFFE_PIPE_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    // Stall counter: counts FULL edges with no advance and no flush, saturating.
    always_comb begin
        stall_d = stall_q;
        if (flush) begin
            stall_d = '0;
        end else if (state_q == FULL && !en && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // Stall counter register, cleared with the rest of the line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`else
    // No stall counter in this build.
`endif

endmodule

// File: tb/tb_dffe_pipe.sv
// Scoreboard bench for dffe_pipe: an 8x4 instance driven by directed vectors
// and a 1x1 instance driven by random din/en against a small reference model.
module tb_dffe_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic [7:0] din0 = '0;
    logic       en0 = 1'b0;
    logic       flush0 = 1'b0;
    logic [7:0] dout0;
    logic       vld0;
    logic [2:0] cnt0;

    logic       din1 = 1'b0;
    logic       en1 = 1'b0;
    logic       flush1 = 1'b0;
    logic       dout1;
    logic       vld1;
    logic [0:0] cnt1;

`ifdef DFFE_PIPE_STALL_CNT_EN
    logic [15:0] stall0;
    logic [15:0] stall1;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] d;
        logic       v;
        logic [2:0] c;
        string      n;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    dffe_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) u0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din0),
        .en       (en0),
        .flush    (flush0),
        .dout     (dout0),
        .dout_vld (vld0),
        .fill_cnt (cnt0)
`ifdef DFFE_PIPE_STALL_CNT_EN
        ,
        .stall_cnt(stall0)
`endif
    );

    dffe_pipe #(.WIDTH(1), .DEPTH(1), .RESET_VAL(1'b0)) u1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din1),
        .en       (en1),
        .flush    (flush1),
        .dout     (dout1),
        .dout_vld (vld1),
        .fill_cnt (cnt1)
`ifdef DFFE_PIPE_STALL_CNT_EN
        ,
        .stall_cnt(stall1)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle on the 8x4 instance (called at a negedge) and queue its outcome.
    task automatic step(input logic [7:0] d, input logic e, input logic f,
                        input logic [7:0] xd, input logic xv, input logic [2:0] xc,
                        input string n);
        exp_t x;
        din0 = d; en0 = e; flush0 = f;
        x.d = xd; x.v = xv; x.c = xc; x.n = n;
        q0.push_back(x);
        @(negedge clk);
    endtask

    // Monitor for the 8x4 instance: compare just after each edge that has an expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            chk({e.n, ".dout"},     32'(dout0), 32'(e.d));
            chk({e.n, ".dout_vld"}, 32'(vld0),  32'(e.v));
            chk({e.n, ".fill_cnt"}, 32'(cnt0),  32'(e.c));
            chk({e.n, ".vld_inv"},  32'(vld0),  32'(cnt0 == 3'd4));
        end
    end

    // Monitor for the 1x1 instance.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q1.size() > 0) begin
            e = q1.pop_front();
            chk({e.n, ".dout"},     32'(dout1), 32'(e.d[0]));
            chk({e.n, ".dout_vld"}, 32'(vld1),  32'(e.v));
            chk({e.n, ".fill_cnt"}, 32'(cnt1),  32'(e.c[0]));
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic m_d, m_v;
        exp_t x;

        // Reset held for two cycles.
        @(negedge clk);
        @(negedge clk);
        chk("rst.dout", 32'(dout0), 32'h00);
        chk("rst.vld",  32'(vld0),  32'h0);
        chk("rst.cnt",  32'(cnt0),  32'h0);
        chk("rst1.vld", 32'(vld1),  32'h0);
        rst_n = 1'b1;

        // Fill after reset.
        step(8'h11, 1, 0, 8'h00, 0, 3'd1, "fill1");
        step(8'h22, 1, 0, 8'h00, 0, 3'd2, "fill2");
        step(8'h33, 1, 0, 8'h00, 0, 3'd3, "fill3");
        step(8'h44, 1, 0, 8'h11, 1, 3'd4, "fill4");

        // Enable gaps: line holds [44,33,22,11] (stage0 first).
        step(8'hA1, 1, 0, 8'h22, 1, 3'd4, "gapA1");
        step(8'h55, 0, 0, 8'h22, 1, 3'd4, "gapH1");
        step(8'hAA, 0, 0, 8'h22, 1, 3'd4, "gapH2");
        step(8'h55, 0, 0, 8'h22, 1, 3'd4, "gapH3");
        step(8'hA2, 1, 0, 8'h33, 1, 3'd4, "gapA2");
        step(8'hA3, 1, 0, 8'h44, 1, 3'd4, "gapA3");
        step(8'hA4, 1, 0, 8'hA1, 1, 3'd4, "gapA4");

        // Flush beats en; 5A must not enter the line.
        step(8'h5A, 1, 1, 8'h00, 0, 3'd0, "flush");
        step(8'hFF, 0, 0, 8'h00, 0, 3'd0, "flushHold");
        step(8'h01, 1, 0, 8'h00, 0, 3'd1, "post1");
        step(8'h01, 1, 0, 8'h00, 0, 3'd2, "post2");
        step(8'h01, 1, 0, 8'h00, 0, 3'd3, "post3");
        step(8'h02, 1, 0, 8'h01, 1, 3'd4, "post4");

        // Asynchronous reset while FULL, between edges.
        en0 = 0; flush0 = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("arstFull.dout", 32'(dout0), 32'h00);
        chk("arstFull.vld",  32'(vld0),  32'h0);
        chk("arstFull.cnt",  32'(cnt0),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset mid-fill.
        step(8'h77, 1, 0, 8'h00, 0, 3'd1, "mid1");
        step(8'h88, 1, 0, 8'h00, 0, 3'd2, "mid2");
        en0 = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("arstMid.dout", 32'(dout0), 32'h00);
        chk("arstMid.vld",  32'(vld0),  32'h0);
        chk("arstMid.cnt",  32'(cnt0),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(8'h99, 1, 0, 8'h00, 0, 3'd1, "afterRst");

        // Enter FULL, stall ten cycles, advance once, then flush.
        step(8'h00, 0, 1, 8'h00, 0, 3'd0, "stFlush");
        step(8'hB1, 1, 0, 8'h00, 0, 3'd1, "stB1");
        step(8'hB2, 1, 0, 8'h00, 0, 3'd2, "stB2");
        step(8'hB3, 1, 0, 8'h00, 0, 3'd3, "stB3");
        step(8'hB4, 1, 0, 8'hB1, 1, 3'd4, "stB4");
        for (int i = 0; i < 10; i++) begin
            step(8'(i), 0, 0, 8'hB1, 1, 3'd4, "stHold");
        end
`ifdef DFFE_PIPE_STALL_CNT_EN
        chk("stall.after10", 32'(stall0), 32'd10);
`endif
        step(8'hB5, 1, 0, 8'hB2, 1, 3'd4, "stB5");
`ifdef DFFE_PIPE_STALL_CNT_EN
        chk("stall.afterEn", 32'(stall0), 32'd10);
`endif
        step(8'h00, 0, 1, 8'h00, 0, 3'd0, "stFlush2");
`ifdef DFFE_PIPE_STALL_CNT_EN
        chk("stall.afterFlush", 32'(stall0), 32'd0);
`endif

        // DEPTH=1, WIDTH=1 random run against a one-register model.
        en0 = 0; flush0 = 0;
        m_d = 1'b0;
        m_v = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            din1   = 1'($urandom_range(0, 1));
            en1    = 1'($urandom_range(0, 1));
            flush1 = ($urandom_range(0, 31) == 0);
            if (flush1) begin
                m_d = 1'b0;
                m_v = 1'b0;
            end else if (en1) begin
                m_d = din1;
                m_v = 1'b1;
            end
            x.d = {7'd0, m_d}; x.v = m_v; x.c = {2'd0, m_v}; x.n = "d1rand";
            q1.push_back(x);
            @(negedge clk);
        end
        en1 = 0; flush1 = 0;

        repeat (2) @(negedge clk);
        chk("scoreboard.drained", 32'(q0.size() + q1.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
